// File: rtl/pulse_delay_line.sv
// pulse_delay_line: multi-channel pulse synchroniser, programmable delay line
// and pulse stretcher with saturating per-channel hit counters.
//
// state | meaning
// IDLE  | pointers and fill counter held at 0, outputs low, edges not counted
// FILL  | edges written and counted, outputs forced low until D cycles elapse
// RUN   | delayed edges emitted as STRETCH-wide pulses, ready high
//
// MAX_DELAY must be at least 2 so the buffer pointer has a nonzero width.
module pulse_delay_line #(
    parameter int CHANNELS      = 16,
    parameter int MAX_DELAY     = 256,
    parameter int DELAY_W       = $clog2(MAX_DELAY + 1),
    parameter int DEFAULT_DELAY = 50,
    parameter int STRETCH       = 4,
    parameter int CNT_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       pulse_in,
    input  logic [DELAY_W-1:0]        delay_cfg,
    input  logic                      delay_load,
    input  logic                      cnt_clear,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic [CHANNELS*CNT_W-1:0] hit_cnt,
    output logic [DELAY_W-1:0]        delay_cur,
    output logic                      ready
);

    localparam int PTR_W = $clog2(MAX_DELAY);
    localparam int SW    = $clog2(STRETCH + 1);

    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(MAX_DELAY - 1);
    localparam logic [DELAY_W-1:0] D_MAX    = DELAY_W'(MAX_DELAY);
    localparam logic [DELAY_W-1:0] D_DEF    = DELAY_W'(DEFAULT_DELAY);
    localparam logic [SW-1:0]      S_LOAD   = SW'(STRETCH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Input pipeline: two synchroniser stages, previous level, edge flag
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] lvl_prev_q, lvl_prev_d;
    logic [CHANNELS-1:0] edge_q, edge_d;

    // Control
    state_t              state_q, state_d;
    logic [DELAY_W-1:0]  fill_q, fill_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [PTR_W-1:0]    wp_q, wp_d;
    logic                ready_q, ready_d;
    logic                active;
    logic                run_next;

    // Delay buffer and read side
    logic [CHANNELS-1:0] mem_q [MAX_DELAY];
    logic [PTR_W-1:0]    rd_addr;
    logic [DELAY_W-1:0]  wp_ext;
    logic [CHANNELS-1:0] rd_data;

    // Output stretchers and hit counters
    logic [SW-1:0]       st_q [CHANNELS];
    logic [SW-1:0]       st_d [CHANNELS];
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    // Synchronise inputs and flag a rising edge when a new high follows a low
    always_comb begin
        sync1_d    = pulse_in;
        sync2_d    = sync1_q;
        lvl_prev_d = sync2_q;
        edge_d     = sync2_q & ~lvl_prev_q;
    end

    // Next state, fill counter and delay register; en=0 overrides a load
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        delay_d = delay_q;
        if (delay_load) begin
            if (delay_cfg == '0) begin
                delay_d = DELAY_W'(1);
            end else if (delay_cfg > D_MAX) begin
                delay_d = D_MAX;
            end else begin
                delay_d = delay_cfg;
            end
        end
        if (!en) begin
            state_d = IDLE;
            fill_d  = '0;
        end else if (delay_load) begin
            state_d = FILL;
            fill_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
                FILL: begin
                    if (fill_q == delay_q - DELAY_W'(1)) begin
                        state_d = RUN;
                    end else begin
                        fill_d = fill_q + DELAY_W'(1);
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // Write pointer runs whenever the next state is not IDLE; read trails by D.
    // The explicit wrap keeps non-power-of-two depths correct.
    always_comb begin
        active   = (state_d != IDLE);
        run_next = (state_d == RUN);
        ready_d  = run_next;
        if (!active) begin
            wp_d = '0;
        end else if (wp_q == PTR_LAST) begin
            wp_d = '0;
        end else begin
            wp_d = wp_q + PTR_W'(1);
        end
        wp_ext = DELAY_W'(wp_q);
        if (wp_ext >= delay_q) begin
            rd_addr = PTR_W'(wp_ext - delay_q);
        end else begin
            rd_addr = PTR_W'(wp_ext + (D_MAX - delay_q));
        end
        rd_data = mem_q[rd_addr];
    end

    // Stretchers reload on a delayed edge, so overlapping pulses merge
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i] = '0;
            if (run_next) begin
                if (rd_data[i]) begin
                    st_d[i] = S_LOAD;
                end else if (st_q[i] != '0) begin
                    st_d[i] = st_q[i] - SW'(1);
                end
            end
            pulse_d[i] = run_next && (st_d[i] != '0);
        end
    end

    // Saturating hit counters; a coincident clear discards the edge
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clear) begin
                cnt_d[i] = '0;
            end else if (edge_q[i] && active && !(&cnt_q[i])) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Register all control, pipeline and output state
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_prev_q <= '0;
            edge_q     <= '0;
            state_q    <= IDLE;
            fill_q     <= '0;
            delay_q    <= D_DEF;
            wp_q       <= '0;
            ready_q    <= 1'b0;
            pulse_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_prev_q <= lvl_prev_d;
            edge_q     <= edge_d;
            state_q    <= state_d;
            fill_q     <= fill_d;
            delay_q    <= delay_d;
            wp_q       <= wp_d;
            ready_q    <= ready_d;
            pulse_q    <= pulse_d;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Buffer write; no clear needed because FILL overwrites every slot read later
    always_ff @(posedge clk) begin
        if (!rst && active) begin
            mem_q[wp_q] <= edge_q;
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign pulse_out = pulse_q;
    assign delay_cur = delay_q;
    assign ready     = ready_q;

endmodule
